// File: rtl/parity_pkg.sv
// Shared definitions for the parity nibble link: receiver state encoding and the
// parity function used by both the transmit and receive sides.
package parity_pkg;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

    localparam int MAX_DATA_W = 16;

    // Zero-extension of narrower payloads does not change the XOR reduction.
    function automatic logic calc_parity(input logic [MAX_DATA_W-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/parity_nibble_rx_if.sv
// Serial input strobe and valid/ready output bundle of the parity nibble receiver.
interface parity_nibble_rx_if #(
    parameter int DATA_W    = 4,
    parameter int ERR_CNT_W = 8
) ();
    logic                 rx_en;
    logic                 rx_bit;
    logic [DATA_W-1:0]    out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output rx_en, rx_bit, out_ready,
        input  out_data, out_valid, parity_err, frame_err, overrun, err_count
    );

    modport slave (
        input  rx_en, rx_bit, out_ready,
        output out_data, out_valid, parity_err, frame_err, overrun, err_count
    );
endinterface

// File: rtl/parity_nibble_rx_out_reg.sv
// One-entry valid/ready holding register for received words; a completion that finds
// the entry occupied and not being drained is dropped and reported as overrun.
module rx_out_reg #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_perr,
    input  logic              load_ferr,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic              drop
);
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              perr_q, perr_d;
    logic              ferr_q, ferr_d;
    logic              overrun_q, overrun_d;
    logic              take;

    always_comb begin
        take      = load & (~valid_q | out_ready);
        drop      = load & valid_q & ~out_ready;
        valid_d   = valid_q & ~out_ready;
        data_d    = data_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        overrun_d = drop;
        if (take) begin
            valid_d = 1'b1;
            data_d  = load_data;
            perr_d  = load_perr;
            ferr_d  = load_ferr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            data_q    <= data_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            overrun_q <= overrun_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overrun    = overrun_q;
endmodule

// File: rtl/parity_nibble_rx.sv
// Parity nibble receiver: deframes start/data/parity/stop, checks parity, counts errors.
//   state  | meaning
//   IDLE   | line idle, waiting for a 0 start bit
//   DATA   | shifting payload in LSB first, bit counter counts down
//   PARITY | capturing the received parity bit
//   STOP   | sampling the stop bit; the frame completes on this strobe
module parity_nibble_rx
    import parity_pkg::*;
#(
    parameter int DATA_W     = 4,
    parameter bit PARITY_ODD = 1'b0,
    parameter int ERR_CNT_W  = 8
) (
    input logic               clk,
    input logic               reset_n,
    parity_nibble_rx_if.slave bus
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]    shift_q, shift_d;
    logic                 par_q, par_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;
    logic [ERR_CNT_W+1:0] err_sum;
    logic                 frm_done, new_perr, new_ferr, drop;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        par_d    = par_q;
        frm_done = 1'b0;
        if (bus.rx_en) begin
            case (state_q)
                IDLE: begin
                    if (!bus.rx_bit) begin
                        state_d = DATA;
                        cnt_d   = CNT_W'(DATA_W - 1);
                    end
                end
                DATA: begin
                    shift_d             = shift_q >> 1;
                    shift_d[DATA_W-1]   = bus.rx_bit;
                    if (cnt_q == '0) state_d = PARITY;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
                PARITY: begin
                    par_d   = bus.rx_bit;
                    state_d = STOP;
                end
                STOP: begin
                    frm_done = 1'b1;
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign new_perr = par_q != calc_parity(MAX_DATA_W'(shift_q), PARITY_ODD);
    assign new_ferr = ~bus.rx_bit;

    // A dropped bad frame costs two counts: one for the error, one for the overrun.
    always_comb begin
        err_sum = (ERR_CNT_W+2)'(err_q) + (ERR_CNT_W+2)'(new_perr | new_ferr)
                + (ERR_CNT_W+2)'(drop);
        err_d   = err_q;
        if (frm_done) begin
            err_d = (err_sum[ERR_CNT_W+1:ERR_CNT_W] != 2'b00) ? '1 : err_sum[ERR_CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            err_q   <= err_d;
        end
    end

    rx_out_reg #(.DATA_W(DATA_W)) u_out_reg (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (frm_done),
        .load_data  (shift_q),
        .load_perr  (new_perr),
        .load_ferr  (new_ferr),
        .out_ready  (bus.out_ready),
        .out_valid  (bus.out_valid),
        .out_data   (bus.out_data),
        .parity_err (bus.parity_err),
        .frame_err  (bus.frame_err),
        .overrun    (bus.overrun),
        .drop       (drop)
    );

    assign bus.err_count = err_q;
endmodule
